rgb_pwm_capture: RTL and testbench

Three-channel PWM duty-cycle capture block. It sits on the receiving end of an RGB PWM link and recovers the per-channel fill factor from the R/G/B PWM lines, producing values that the RGB PWM generator side takes as inputs. The source PWM period is exactly `FILL_FACTOR_MAX` CE ticks and uses the same CE rate. Under that condition, counting active ticks over any window of one period yields the fill factor, regardless of the source's phase.

---
 rtl/rgb_pwm_capture.sv | 199 +++++++++++++++++++
 tb/tb_rgb_pwm_capture.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_capture.sv
// -----------------------------------------------------------------------------
// rgb_pwm_capture
//
// Recovers the fill factor of three PWM lines (R/G/B). The source PWM period
// equals FILL_FACTOR_MAX CE ticks at the same CE rate. Counting "on" samples
// over any window of FILL_FACTOR_MAX ticks therefore gives the fill factor,
// whatever the source phase.
//
// Optional feature macro: RGB_PWM_CAPTURE_SYNC_EN
//   defined   : each line passes through a 2-flop synchronizer, clocked every
//               CLK and independent of CE. Adds 2 CLK of input latency.
//   undefined : lines are sampled directly at the CE edge. They must be
//               synchronous to CLK.
//
// Parameters:
//   ACT_STATE            - line level regarded as "on"
//   FILL_FACTOR_MAX      - PWM period / capture window in CE ticks (>= 2)
//   FILL_FACTOR_BITS_NUM - width of the fill-factor outputs
//
// Ports:
//   CLK           in   clock
//   CLR           in   synchronous active-high reset, has priority over CE
//   CE            in   tick enable, one sample per CLK cycle with CE=1
//   R, G, B       in   PWM lines
//   R/G/B_FILL_FACTOR out  last captured fill factors
//   VALID         out  one-CLK pulse when new fill factors are loaded
//   STABLE        out  last two completed windows gave identical triplets
//   DBG_STATE     out  FSM state (0 = FIRST, 1 = RUN)
//
// Output handshake: VALID is a push-only strobe with no ready. It is high for
// exactly the one CLK cycle after the edge that loads new fill factors. The
// fill-factor outputs and STABLE stay constant until the next such edge.
// -----------------------------------------------------------------------------
module rgb_pwm_capture #(
  parameter bit ACT_STATE            = 1'b1,
  parameter int FILL_FACTOR_MAX      = 255,
  parameter int FILL_FACTOR_BITS_NUM = $clog2(FILL_FACTOR_MAX + 1)
) (
  input  logic                            CLK,
  input  logic                            CLR,
  input  logic                            CE,
  input  logic                            R,
  input  logic                            G,
  input  logic                            B,
  output logic [FILL_FACTOR_BITS_NUM-1:0] R_FILL_FACTOR,
  output logic [FILL_FACTOR_BITS_NUM-1:0] G_FILL_FACTOR,
  output logic [FILL_FACTOR_BITS_NUM-1:0] B_FILL_FACTOR,
  output logic                            VALID,
  output logic                            STABLE,
  output logic                            DBG_STATE
);

  localparam int W  = FILL_FACTOR_BITS_NUM;
  localparam int CW = $clog2(FILL_FACTOR_MAX + 1);
  localparam logic [CW-1:0] WCNT_LAST = CW'(FILL_FACTOR_MAX - 1);

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Line sampling: {R, G, B}
  // ---------------------------------------------------------------------------
  logic [2:0] line;

`ifdef RGB_PWM_CAPTURE_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  // Stages reset to the "off" level, so the first post-reset samples count
  // as inactive instead of as stale data.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      sync1_q <= {3{~ACT_STATE}};
      sync2_q <= {3{~ACT_STATE}};
    end else begin
      sync1_q <= {R, G, B};
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;
`else
  assign line = {R, G, B};
`endif

  logic s_r, s_g, s_b;
  assign s_r = (line[2] == ACT_STATE);
  assign s_g = (line[1] == ACT_STATE);
  assign s_b = (line[0] == ACT_STATE);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [W-1:0]  acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
  logic [W-1:0]  ff_r_q, ff_r_d, ff_g_q, ff_g_d, ff_b_q, ff_b_d;
  logic [W-1:0]  prev_r_q, prev_r_d, prev_g_q, prev_g_d, prev_b_q, prev_b_d;
  logic          valid_q, valid_d;
  logic          stable_q, stable_d;

  // Window totals include the sample consumed on the closing edge.
  logic [W-1:0] sum_r, sum_g, sum_b;
  assign sum_r = acc_r_q + {{(W-1){1'b0}}, s_r};
  assign sum_g = acc_g_q + {{(W-1){1'b0}}, s_g};
  assign sum_b = acc_b_q + {{(W-1){1'b0}}, s_b};

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= ST_FIRST;
      wcnt_q   <= '0;
      acc_r_q  <= '0;
      acc_g_q  <= '0;
      acc_b_q  <= '0;
      ff_r_q   <= '0;
      ff_g_q   <= '0;
      ff_b_q   <= '0;
      prev_r_q <= '0;
      prev_g_q <= '0;
      prev_b_q <= '0;
      valid_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      acc_r_q  <= acc_r_d;
      acc_g_q  <= acc_g_d;
      acc_b_q  <= acc_b_d;
      ff_r_q   <= ff_r_d;
      ff_g_q   <= ff_g_d;
      ff_b_q   <= ff_b_d;
      prev_r_q <= prev_r_d;
      prev_g_q <= prev_g_d;
      prev_b_q <= prev_b_d;
      valid_q  <= valid_d;
      stable_q <= stable_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    acc_r_d  = acc_r_q;
    acc_g_d  = acc_g_q;
    acc_b_d  = acc_b_q;
    ff_r_d   = ff_r_q;
    ff_g_d   = ff_g_q;
    ff_b_d   = ff_b_q;
    prev_r_d = prev_r_q;
    prev_g_d = prev_g_q;
    prev_b_d = prev_b_q;
    valid_d  = 1'b0;
    stable_d = stable_q;

    if (CE) begin
      if (wcnt_q == WCNT_LAST) begin
        wcnt_d   = '0;
        acc_r_d  = '0;
        acc_g_d  = '0;
        acc_b_d  = '0;
        ff_r_d   = sum_r;
        ff_g_d   = sum_g;
        ff_b_d   = sum_b;
        prev_r_d = sum_r;
        prev_g_d = sum_g;
        prev_b_d = sum_b;
        valid_d  = 1'b1;
        case (state_q)
          ST_FIRST: begin
            // No earlier window to compare against yet.
            stable_d = 1'b0;
            state_d  = ST_RUN;
          end
          default: begin
            stable_d = (sum_r == prev_r_q) && (sum_g == prev_g_q) &&
                       (sum_b == prev_b_q);
          end
        endcase
      end else begin
        wcnt_d  = wcnt_q + 1'b1;
        acc_r_d = sum_r;
        acc_g_d = sum_g;
        acc_b_d = sum_b;
      end
    end
  end

  assign R_FILL_FACTOR = ff_r_q;
  assign G_FILL_FACTOR = ff_g_q;
  assign B_FILL_FACTOR = ff_b_q;
  assign VALID         = valid_q;
  assign STABLE        = stable_q;
  assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_rgb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm_capture
//
// Two instances share CLK/CLR/CE:
//   dut_a - ACT_STATE=1, driven by a PWM source with per-case duties
//   dut_b - ACT_STATE=0, driven by inverted PWM with duties 10/20/30
// The PWM sources tick on the same CE as the DUTs, with period 255.
// -----------------------------------------------------------------------------
module tb_rgb_pwm_capture;

  localparam int W      = 8;
  localparam int PERIOD = 255;
  localparam int EW     = 1 + 3 * W;  // {stable, r, g, b}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic clr;
  logic ce;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic         r_a, g_a, b_a, r_b, g_b, b_b;
  logic [W-1:0] rf_a, gf_a, bf_a, rf_b, gf_b, bf_b;
  logic         valid_a, stable_a, dbg_a, valid_b, stable_b, dbg_b;

  rgb_pwm_capture #(.ACT_STATE(1'b1), .FILL_FACTOR_MAX(PERIOD)) dut_a (
    .CLK(clk), .CLR(clr), .CE(ce), .R(r_a), .G(g_a), .B(b_a),
    .R_FILL_FACTOR(rf_a), .G_FILL_FACTOR(gf_a), .B_FILL_FACTOR(bf_a),
    .VALID(valid_a), .STABLE(stable_a), .DBG_STATE(dbg_a)
  );

  rgb_pwm_capture #(.ACT_STATE(1'b0), .FILL_FACTOR_MAX(PERIOD)) dut_b (
    .CLK(clk), .CLR(clr), .CE(ce), .R(r_b), .G(g_b), .B(b_b),
    .R_FILL_FACTOR(rf_b), .G_FILL_FACTOR(gf_b), .B_FILL_FACTOR(bf_b),
    .VALID(valid_b), .STABLE(stable_b), .DBG_STATE(dbg_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_a[$];
  logic [EW-1:0] exp_b[$];
  int n_checks;
  int n_fail;
  int rst_cyc;
  int cur_div;
  int case_cyc;

  // Source model: channels 0..2 feed dut_a, 3..5 feed dut_b.
  int src_cnt[6];
  int src_duty[6];
  int r_next;  // pending red duty, applied at the start of a source period

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First window after reset: with the synchronizer, the first two samples
  // are forced inactive when CE runs every cycle.
  function automatic int first_val(input int duty, input int ph, input int div);
    int v;
    v = duty;
`ifdef RGB_PWM_CAPTURE_SYNC_EN
    if (div == 1) begin
      if (((ph + PERIOD - 2) % PERIOD) < duty) v--;
      if (((ph + PERIOD - 1) % PERIOD) < duty) v--;
    end
`endif
    return v;
  endfunction

  function automatic logic [EW-1:0] pack(input int st, input int r, input int g,
                                         input int b);
    return {st[0], r[W-1:0], g[W-1:0], b[W-1:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left at a negedge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    logic ce_now;
    if (src_cnt[0] == 0) src_duty[0] = r_next;
    ce_now = (cur_div == 1) ? 1'b1 : ((case_cyc % cur_div) == cur_div - 1);
    ce  = ce_now;
    r_a = (src_cnt[0] < src_duty[0]);
    g_a = (src_cnt[1] < src_duty[1]);
    b_a = (src_cnt[2] < src_duty[2]);
    r_b = !(src_cnt[3] < src_duty[3]);
    g_b = !(src_cnt[4] < src_duty[4]);
    b_b = !(src_cnt[5] < src_duty[5]);
    @(negedge clk);
    if (ce_now) begin
      for (int i = 0; i < 6; i++) src_cnt[i] = (src_cnt[i] + 1) % PERIOD;
    end
    case_cyc++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle CLR with CE=1 (CLR must win), then check the cleared outputs.
  task automatic do_reset(input int dr, input int dg, input int db,
                          input int pr, input int pg, input int pb,
                          input int div);
    clr      = 1'b1;
    cur_div  = 1;
    case_cyc = 0;
    tick();
    clr = 1'b0;
    rst_cyc = cyc;
    chk("rst_rf_a", int'(rf_a), 0);
    chk("rst_gf_a", int'(gf_a), 0);
    chk("rst_bf_a", int'(bf_a), 0);
    chk("rst_valid_a", int'(valid_a), 0);
    chk("rst_stable_a", int'(stable_a), 0);
    chk("rst_state_a", int'(dbg_a), 0);
    chk("rst_rf_b", int'(rf_b), 0);
    chk("rst_valid_b", int'(valid_b), 0);
    chk("rst_stable_b", int'(stable_b), 0);
    chk("rst_state_b", int'(dbg_b), 0);
    src_duty[0] = dr; src_duty[1] = dg; src_duty[2] = db;
    r_next      = dr;
    src_cnt[0]  = pr; src_cnt[1]  = pg; src_cnt[2]  = pb;
    src_duty[3] = 10; src_duty[4] = 20; src_duty[5] = 30;
    src_cnt[3]  = 40; src_cnt[4]  = 70; src_cnt[5]  = 100;
    cur_div  = div;
    case_cyc = 0;
  endtask

  task automatic run_until_empty(input int maxc);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_timeout", exp_a.size() + exp_b.size(), 0);
    exp_a.delete();
    exp_b.delete();
  endtask

  // dut_b expectations are the same in every case: 10/20/30.
  task automatic push_b(input int nwin, input int div);
    int fr, fg, fb;
    fr = first_val(10, 40, div);
    fg = first_val(20, 70, div);
    fb = first_val(30, 100, div);
    for (int w = 0; w < nwin; w++) begin
      if (w == 0) exp_b.push_back(pack(0, fr, fg, fb));
      else if (w == 1)
        exp_b.push_back(pack(int'(fr == 10 && fg == 20 && fb == 30), 10, 20, 30));
      else exp_b.push_back(pack(1, 10, 20, 30));
    end
  endtask

  task automatic run_case(input int dr, input int dg, input int db,
                          input int pr, input int pg, input int pb,
                          input int nwin, input int div);
    int fr, fg, fb;
    do_reset(dr, dg, db, pr, pg, pb, div);
    fr = first_val(dr, pr, div);
    fg = first_val(dg, pg, div);
    fb = first_val(db, pb, div);
    for (int w = 0; w < nwin; w++) begin
      if (w == 0) exp_a.push_back(pack(0, fr, fg, fb));
      else if (w == 1)
        exp_a.push_back(pack(int'(fr == dr && fg == dg && fb == db), dr, dg, db));
      else exp_a.push_back(pack(1, dr, dg, db));
    end
    push_b(nwin, div);
    run_until_empty(nwin * PERIOD * div + 20);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: pop and compare on every VALID
  // ---------------------------------------------------------------------------
  task automatic check_valid(input string tag, input logic [EW-1:0] e,
                             input int r, input int g, input int b,
                             input int st);
    chk({"r_", tag}, r, int'(e[3*W-1:2*W]));
    chk({"g_", tag}, g, int'(e[2*W-1:W]));
    chk({"b_", tag}, b, int'(e[W-1:0]));
    chk({"stable_", tag}, st, int'(e[EW-1]));
  endtask

  initial begin : mon_a
    int last_v;
    int prev_v;
    logic [EW-1:0] e;
    last_v = 0;
    prev_v = 0;
    forever begin
      @(negedge clk);
      if (valid_a === 1'b1) begin
        if (exp_a.size() == 0) chk("unexpected_valid_a", 1, 0);
        else begin
          e = exp_a.pop_front();
          check_valid("a", e, int'(rf_a), int'(gf_a), int'(bf_a), int'(stable_a));
        end
        chk("gap_a", cyc - ((last_v > rst_cyc) ? last_v : rst_cyc), PERIOD * cur_div);
        chk("width_a", prev_v, 0);
        last_v = cyc;
      end
      prev_v = (valid_a === 1'b1) ? 1 : 0;
    end
  end

  initial begin : mon_b
    int last_v;
    int prev_v;
    logic [EW-1:0] e;
    last_v = 0;
    prev_v = 0;
    forever begin
      @(negedge clk);
      if (valid_b === 1'b1) begin
        if (exp_b.size() == 0) chk("unexpected_valid_b", 1, 0);
        else begin
          e = exp_b.pop_front();
          check_valid("b", e, int'(rf_b), int'(gf_b), int'(bf_b), int'(stable_b));
        end
        chk("gap_b", cyc - ((last_v > rst_cyc) ? last_v : rst_cyc), PERIOD * cur_div);
        chk("width_b", prev_v, 0);
        last_v = cyc;
      end
      prev_v = (valid_b === 1'b1) ? 1 : 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int fr;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_cyc  = 0;
    cur_div  = 1;
    case_cyc = 0;
    r_next   = 0;
    for (int i = 0; i < 6; i++) begin
      src_cnt[i]  = 0;
      src_duty[i] = 0;
    end
    clr = 1'b1;
    ce  = 1'b0;
    r_a = 1'b0; g_a = 1'b0; b_a = 1'b0;
    r_b = 1'b1; g_b = 1'b1; b_b = 1'b1;
    repeat (3) @(negedge clk);

    // Constant duty 64/128/200 at arbitrary phases.
    run_case(64, 128, 200, 37, 100, 3, 3, 1);

    // Let the next window reach WCNT=100; run_case then resets mid-window
    // with non-zero outputs and STABLE=1 still showing.
    run_cycles(100);

    // Extremes: always on, always off, always on.
    run_case(255, 0, 255, 10, 20, 30, 2, 1);

    // CE every 4th cycle, source ticking on the same CE.
    run_case(64, 128, 200, 37, 100, 3, 3, 4);

    // Duty change 64 -> 65 on red. Red phase 150 puts the source period
    // start 105 ticks into each window; the change is armed during window 2
    // after that point, so it lands inside window 3, which then holds only
    // the new duty's "on" ticks.
    do_reset(64, 128, 200, 150, 150, 250, 1);
    fr = first_val(64, 150, 1);
    exp_a.push_back(pack(0, fr, 128, 200));
    exp_a.push_back(pack(int'(fr == 64), 64, 128, 200));
    exp_a.push_back(pack(0, 65, 128, 200));
    exp_a.push_back(pack(1, 65, 128, 200));
    push_b(4, 1);
    run_cycles(455);
    r_next = 65;
    run_until_empty(4 * PERIOD + 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
